// File: rtl/decode_pkg.sv
// Decode-stage shared types: opcode constants, immediate/opclass enums and the
// opcode-to-control decode and immediate generation helpers.
package decode_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

    typedef enum logic [3:0] {
        CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD, CLS_STORE,
        CLS_OP_IMM, CLS_OP, CLS_OP_IMM_32, CLS_OP_32, CLS_ILLEGAL
    } opclass_t;

    typedef struct packed {
        opclass_t  opclass;
        imm_type_t imm_type;
        logic      uses_rs1;
        logic      uses_rs2;
        logic      writes_rd;
    } dec_info_t;

    // Unrecognised opcodes use no sources, so they can never stall.
    function automatic dec_info_t decode_opcode(input logic [6:0] opcode);
        dec_info_t d;
        d = '{opclass: CLS_ILLEGAL, imm_type: IMM_NONE, uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0};
        case (opcode)
            OPC_LUI:       d = '{CLS_LUI,       IMM_U,    1'b0, 1'b0, 1'b1};
            OPC_AUIPC:     d = '{CLS_AUIPC,     IMM_U,    1'b0, 1'b0, 1'b1};
            OPC_JAL:       d = '{CLS_JAL,       IMM_J,    1'b0, 1'b0, 1'b1};
            OPC_JALR:      d = '{CLS_JALR,      IMM_I,    1'b1, 1'b0, 1'b1};
            OPC_BRANCH:    d = '{CLS_BRANCH,    IMM_B,    1'b1, 1'b1, 1'b0};
            OPC_LOAD:      d = '{CLS_LOAD,      IMM_I,    1'b1, 1'b0, 1'b1};
            OPC_STORE:     d = '{CLS_STORE,     IMM_S,    1'b1, 1'b1, 1'b0};
            OPC_OP_IMM:    d = '{CLS_OP_IMM,    IMM_I,    1'b1, 1'b0, 1'b1};
            OPC_OP:        d = '{CLS_OP,        IMM_NONE, 1'b1, 1'b1, 1'b1};
            OPC_OP_IMM_32: d = '{CLS_OP_IMM_32, IMM_I,    1'b1, 1'b0, 1'b1};
            OPC_OP_32:     d = '{CLS_OP_32,     IMM_NONE, 1'b1, 1'b1, 1'b1};
            default:       d = '{CLS_ILLEGAL,   IMM_NONE, 1'b0, 1'b0, 1'b0};
        endcase
        return d;
    endfunction

    function automatic logic [XLEN-1:0] gen_imm(input imm_type_t t, input logic [31:0] ir);
        logic [XLEN-1:0] imm;
        case (t)
            IMM_I:   imm = {{52{ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   imm = {{32{ir[31]}}, ir[31:12], 12'h000};
            IMM_J:   imm = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// 32x64 integer register file, two combinational read ports, one write port.
// DECODE_WB_BYPASS_EN makes a same-cycle write visible on the read ports.
module reg_file_2r1w
    import decode_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [4:0]           i_waddr,
    input  logic [XLEN-1:0]      i_wdata,
    input  logic [1:0][4:0]      i_raddr,
    output logic [1:0][XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] r_mem [0:31];

    always_ff @(posedge i_clk) begin
        if (i_we && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic w_hit;
`ifdef DECODE_WB_BYPASS_EN
            assign w_hit = i_we && (i_waddr == i_raddr[gi]);
`else
            assign w_hit = 1'b0;
`endif
            // x0 is never stored; force it to zero at the read side.
            assign o_rdata[gi] = (i_raddr[gi] == 5'd0) ? '0 :
                                 (w_hit ? i_wdata : r_mem[i_raddr[gi]]);
        end
    endgenerate

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage: regfile read, immediate gen, busy-bit scoreboard, EXE latch.
// DECODE_WB_BYPASS_EN forwards WB_DATA and lets a same-cycle writeback release a stall.
module decode_stage
    import decode_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            DE_V,
    input  logic [XLEN-1:0] DE_PC,
    input  logic [XLEN-1:0] DE_NPC,
    input  logic [31:0]     DE_IR,
    input  logic            WB_V,
    input  logic            WB_WE,
    input  logic [4:0]      WB_RD,
    input  logic [XLEN-1:0] WB_DATA,
    output logic            V_DEP_STALL,
    output logic            V_DE_FE_BR_STALL,
    output logic            EXE_V,
    output logic [XLEN-1:0] EXE_PC,
    output logic [XLEN-1:0] EXE_NPC,
    output logic [31:0]     EXE_IR,
    output logic [XLEN-1:0] EXE_SRC1,
    output logic [XLEN-1:0] EXE_SRC2,
    output logic [XLEN-1:0] EXE_IMM,
    output logic [4:0]      EXE_RD,
    output logic            EXE_WE,
    output logic            EXE_ILLEGAL
);

    dec_info_t             w_dec;
    logic [1:0][4:0]       w_rs;
    logic [1:0]            w_use;
    logic [1:0][XLEN-1:0]  w_rdata;
    logic [1:0]            w_blocked;
    logic [4:0]            w_rd;
    logic                  w_wb_fire;
    logic                  w_issue;
    logic                  w_we;
    logic [31:0]           r_busy;
    logic [31:0]           w_busy_next;

    assign w_dec     = decode_opcode(DE_IR[6:0]);
    assign w_rs[0]   = DE_IR[19:15];
    assign w_rs[1]   = DE_IR[24:20];
    assign w_use[0]  = w_dec.uses_rs1;
    assign w_use[1]  = w_dec.uses_rs2;
    assign w_rd      = DE_IR[11:7];
    assign w_wb_fire = WB_V && WB_WE;
    assign w_we      = w_dec.writes_rd && (w_rd != 5'd0);

    reg_file_2r1w u_rf (
        .i_clk   (CLK),
        .i_we    (w_wb_fire && !RESET),
        .i_waddr (WB_RD),
        .i_wdata (WB_DATA),
        .i_raddr (w_rs),
        .o_rdata (w_rdata)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic w_release;
`ifdef DECODE_WB_BYPASS_EN
            assign w_release = w_wb_fire && (WB_RD == w_rs[gi]);
`else
            assign w_release = 1'b0;
`endif
            assign w_blocked[gi] = w_use[gi] && (w_rs[gi] != 5'd0) &&
                                   r_busy[w_rs[gi]] && !w_release;
        end
    endgenerate

    assign V_DEP_STALL      = DE_V && (|w_blocked);
    assign V_DE_FE_BR_STALL = DE_V && ((w_dec.opclass == CLS_BRANCH) ||
                                       (w_dec.opclass == CLS_JAL) ||
                                       (w_dec.opclass == CLS_JALR));
    assign w_issue          = DE_V && !V_DEP_STALL;

    // Set is applied after clear so an issuing writer wins over a same-cycle WB.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wb_fire) begin
            w_busy_next[WB_RD] = 1'b0;
        end
        if (w_issue && w_we) begin
            w_busy_next[w_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            EXE_V       <= 1'b0;
            EXE_PC      <= '0;
            EXE_NPC     <= '0;
            EXE_IR      <= '0;
            EXE_SRC1    <= '0;
            EXE_SRC2    <= '0;
            EXE_IMM     <= '0;
            EXE_RD      <= '0;
            EXE_WE      <= 1'b0;
            EXE_ILLEGAL <= 1'b0;
        end else if (w_issue) begin
            EXE_V       <= 1'b1;
            EXE_PC      <= DE_PC;
            EXE_NPC     <= DE_NPC;
            EXE_IR      <= DE_IR;
            EXE_SRC1    <= w_rdata[0];
            EXE_SRC2    <= w_rdata[1];
            EXE_IMM     <= gen_imm(w_dec.imm_type, DE_IR);
            EXE_RD      <= w_rd;
            EXE_WE      <= w_we;
            EXE_ILLEGAL <= (w_dec.opclass == CLS_ILLEGAL);
        end else begin
            EXE_V       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model (honours DECODE_WB_BYPASS_EN).
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        RESET, DE_V, WB_V, WB_WE;
    logic [63:0] DE_PC, DE_NPC, WB_DATA;
    logic [31:0] DE_IR;
    logic [4:0]  WB_RD;
    logic        V_DEP_STALL, V_DE_FE_BR_STALL, EXE_V, EXE_WE, EXE_ILLEGAL;
    logic [63:0] EXE_PC, EXE_NPC, EXE_SRC1, EXE_SRC2, EXE_IMM;
    logic [31:0] EXE_IR;
    logic [4:0]  EXE_RD;

    always #5 CLK = ~CLK;

    decode_stage dut (
        .CLK(CLK), .RESET(RESET), .DE_V(DE_V), .DE_PC(DE_PC), .DE_NPC(DE_NPC), .DE_IR(DE_IR),
        .WB_V(WB_V), .WB_WE(WB_WE), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
        .V_DEP_STALL(V_DEP_STALL), .V_DE_FE_BR_STALL(V_DE_FE_BR_STALL),
        .EXE_V(EXE_V), .EXE_PC(EXE_PC), .EXE_NPC(EXE_NPC), .EXE_IR(EXE_IR),
        .EXE_SRC1(EXE_SRC1), .EXE_SRC2(EXE_SRC2), .EXE_IMM(EXE_IMM), .EXE_RD(EXE_RD),
        .EXE_WE(EXE_WE), .EXE_ILLEGAL(EXE_ILLEGAL)
    );

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [63:0] m_regs [32];
    bit          m_busy [32];
    logic        m_exe_v, m_exe_we, m_exe_ill;
    logic [63:0] m_exe_pc, m_exe_npc, m_exe_src1, m_exe_src2, m_exe_imm;
    logic [31:0] m_exe_ir;
    logic [4:0]  m_exe_rd;
    bit          m_dep, m_br;
    logic        obs_dep, obs_br;

    task automatic classify(input logic [31:0] ir, output bit legal, output bit u1,
                            output bit u2, output bit wr, output bit ctl, output logic [63:0] imm);
        longint i_imm, s_imm, b_imm, u_imm, j_imm;
        i_imm = longint'($signed(ir[31:20]));
        s_imm = longint'($signed({ir[31:25], ir[11:7]}));
        b_imm = longint'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
        u_imm = longint'($signed({ir[31:12], 12'h000}));
        j_imm = longint'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
        legal = 1; u1 = 0; u2 = 0; wr = 0; ctl = 0; imm = 64'd0;
        case (ir[6:0])
            7'h37:   begin wr = 1; imm = u_imm; end
            7'h17:   begin wr = 1; imm = u_imm; end
            7'h6F:   begin wr = 1; ctl = 1; imm = j_imm; end
            7'h67:   begin u1 = 1; wr = 1; ctl = 1; imm = i_imm; end
            7'h63:   begin u1 = 1; u2 = 1; ctl = 1; imm = b_imm; end
            7'h03:   begin u1 = 1; wr = 1; imm = i_imm; end
            7'h23:   begin u1 = 1; u2 = 1; imm = s_imm; end
            7'h13:   begin u1 = 1; wr = 1; imm = i_imm; end
            7'h33:   begin u1 = 1; u2 = 1; wr = 1; end
            7'h1B:   begin u1 = 1; wr = 1; imm = i_imm; end
            7'h3B:   begin u1 = 1; u2 = 1; wr = 1; end
            default: legal = 0;
        endcase
    endtask

    // One clock: stalls checked at negedge, EXE latch checked 1 time unit after posedge.
    task automatic tick();
        bit legal, u1, u2, wr, ctl, fire, blk1, blk2, issue, we;
        logic [63:0] imm, v1, v2;
        logic [4:0] rs1, rs2, rd;
        @(negedge CLK);
        classify(DE_IR, legal, u1, u2, wr, ctl, imm);
        rs1 = DE_IR[19:15]; rs2 = DE_IR[24:20]; rd = DE_IR[11:7];
        fire = WB_V && WB_WE;
        blk1 = u1 && rs1 != 0 && m_busy[rs1] && !(BYP && fire && WB_RD == rs1);
        blk2 = u2 && rs2 != 0 && m_busy[rs2] && !(BYP && fire && WB_RD == rs2);
        m_dep = DE_V && (blk1 || blk2);
        m_br  = DE_V && ctl;
        obs_dep = V_DEP_STALL;
        obs_br  = V_DE_FE_BR_STALL;
        check("dep_stall", obs_dep, m_dep);
        check("br_stall", obs_br, m_br);
        v1 = (rs1 == 0) ? 64'd0 : ((BYP && fire && WB_RD == rs1) ? WB_DATA : m_regs[rs1]);
        v2 = (rs2 == 0) ? 64'd0 : ((BYP && fire && WB_RD == rs2) ? WB_DATA : m_regs[rs2]);
        issue = DE_V && !m_dep;
        we = wr && rd != 0;
        if (RESET) begin
            m_exe_v = 0; m_exe_we = 0; m_exe_ill = 0; m_exe_pc = 0; m_exe_npc = 0;
            m_exe_ir = 0; m_exe_src1 = 0; m_exe_src2 = 0; m_exe_imm = 0; m_exe_rd = 0;
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else begin
            m_exe_v = issue;
            if (issue) begin
                m_exe_pc = DE_PC; m_exe_npc = DE_NPC; m_exe_ir = DE_IR;
                m_exe_src1 = v1; m_exe_src2 = v2; m_exe_imm = imm; m_exe_rd = rd;
                m_exe_we = we; m_exe_ill = !legal;
            end
            if (fire) m_busy[WB_RD] = 0;
            if (issue && we) m_busy[rd] = 1;
            m_busy[0] = 0;
            if (fire && WB_RD != 0) m_regs[WB_RD] = WB_DATA;
        end
        @(posedge CLK);
        #1;
        check("exe_v", EXE_V, m_exe_v);
        check("exe_pc", EXE_PC, m_exe_pc);
        check("exe_npc", EXE_NPC, m_exe_npc);
        check("exe_ir", EXE_IR, m_exe_ir);
        check("exe_src1", EXE_SRC1, m_exe_src1);
        check("exe_src2", EXE_SRC2, m_exe_src2);
        check("exe_imm", EXE_IMM, m_exe_imm);
        check("exe_rd", EXE_RD, m_exe_rd);
        check("exe_we", EXE_WE, m_exe_we);
        check("exe_illegal", EXE_ILLEGAL, m_exe_ill);
    endtask

    task automatic set_de(input logic v, input logic [31:0] ir, input logic [63:0] pc);
        DE_V = v; DE_IR = ir; DE_PC = pc; DE_NPC = pc + 64'd4;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd, input logic [63:0] data);
        WB_V = v; WB_WE = v; WB_RD = rd; WB_DATA = data;
    endtask

    logic [6:0]  ops [11];
    logic [31:0] ir;

    initial begin
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B};
        RESET = 1;
        set_de(0, 32'd0, 64'd0);
        set_wb(0, 5'd0, 64'd0);
        tick();
        tick();
        check("rst_exe_v", EXE_V, 64'd0);
        check("rst_exe_we", EXE_WE, 64'd0);
        check("rst_exe_imm", EXE_IMM, 64'd0);
        RESET = 0;

        // Give every register a known value.
        for (int r = 1; r < 32; r++) begin
            set_wb(1, 5'(r), {$urandom, $urandom});
            tick();
        end
        set_wb(0, 5'd0, 64'd0);

        set_de(1, 32'h00500093, 64'h1000);          // ADDI x1,x0,5
        tick();
        check("addi_v", EXE_V, 64'd1);
        check("addi_imm", EXE_IMM, 64'd5);
        check("addi_rd", EXE_RD, 64'd1);
        check("addi_we", EXE_WE, 64'd1);

        set_de(1, 32'h00108133, 64'h1004);          // ADD x2,x1,x1
        tick();
        check("raw_stall1", obs_dep, 64'd1);
        check("raw_bubble1", EXE_V, 64'd0);
        tick();
        check("raw_stall2", obs_dep, 64'd1);
        set_wb(1, 5'd1, 64'd5);
        tick();
`ifdef DECODE_WB_BYPASS_EN
        check("byp_release", obs_dep, 64'd0);
        check("byp_issue", EXE_V, 64'd1);
        check("byp_src1", EXE_SRC1, 64'd5);
        check("byp_src2", EXE_SRC2, 64'd5);
        set_wb(0, 5'd0, 64'd0);
`else
        check("nobyp_stall_wb", obs_dep, 64'd1);
        check("nobyp_bubble", EXE_V, 64'd0);
        set_wb(0, 5'd0, 64'd0);
        tick();
        check("nobyp_issue", EXE_V, 64'd1);
        check("nobyp_src1", EXE_SRC1, 64'd5);
        check("nobyp_src2", EXE_SRC2, 64'd5);
`endif

        set_de(1, 32'hFE000CE3, 64'h1008);          // BEQ x0,x0,-8
        tick();
        check("beq_br_stall", obs_br, 64'd1);
        check("beq_imm", EXE_IMM, 64'hFFFF_FFFF_FFFF_FFF8);
        check("beq_we", EXE_WE, 64'd0);
        set_de(1, 32'h00010333, 64'h100C);          // ADD x6,x2,x0: x2 still busy
        tick();
        check("beq_sb_kept", obs_dep, 64'd1);
        set_de(0, 32'h00010333, 64'h100C);
        set_wb(1, 5'd2, 64'd10);
        tick();
        set_wb(0, 5'd0, 64'd0);

        set_de(1, 32'h00100013, 64'h1010);          // ADDI x0,x0,1
        tick();
        check("x0_we", EXE_WE, 64'd0);
        set_de(1, 32'h00000233, 64'h1014);          // ADD x4,x0,x0
        tick();
        check("x0_nostall", obs_dep, 64'd0);
        check("x0_src1", EXE_SRC1, 64'd0);
        check("x0_src2", EXE_SRC2, 64'd0);

        set_de(1, 32'h123451B7, 64'h1018);          // LUI x3,0x12345 with WB to x3
        set_wb(1, 5'd3, 64'h33);
        tick();
        check("lui_imm", EXE_IMM, 64'h1234_5000);
        set_wb(0, 5'd0, 64'd0);
        set_de(1, 32'h000182B3, 64'h101C);          // ADD x5,x3,x0
        tick();
        check("lui_set_wins", obs_dep, 64'd1);

        set_de(1, 32'hFFFFFFFF, 64'h1020);
        tick();
        check("ill_flag", EXE_ILLEGAL, 64'd1);
        check("ill_we", EXE_WE, 64'd0);
        check("ill_issue", EXE_V, 64'd1);

        set_de(1, 32'h000182B3, 64'h1024);
        tick();
        check("pre_rst_stall", obs_dep, 64'd1);
        RESET = 1;
        tick();
        check("rst_bubble", EXE_V, 64'd0);
        RESET = 0;
        tick();
        check("rst_clears_sb", obs_dep, 64'd0);

        // Randomized traffic; a stalled DE instruction is held like fetch would.
        for (int c = 0; c < 500; c++) begin
            if (!(DE_V && m_dep)) begin
                ir = $urandom;
                ir[6:0]   = ops[$urandom_range(0, 10)];
                ir[11:7]  = 5'($urandom_range(0, 7));
                ir[19:15] = 5'($urandom_range(0, 7));
                ir[24:20] = 5'($urandom_range(0, 7));
                set_de(($urandom_range(0, 9) < 8), ir, {$urandom, $urandom});
            end
            WB_V    = ($urandom_range(0, 1) == 1);
            WB_WE   = ($urandom_range(0, 4) != 0);
            WB_RD   = 5'($urandom_range(0, 7));
            WB_DATA = {$urandom, $urandom};
            RESET   = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
